// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers:
// slot-state encoding and the default field widths at each pipeline boundary.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_FULL  = 2'd2
   } ps_state_t;

   localparam int OCC_W = 2;

   // {pred_taken} / {pc, instr}
   localparam int IFID_CTRL_W  = 1;
   localparam int IFID_DATA_W  = 64;
   // {alu_op[3:0], alu_src, mem_read, mem_write, reg_write} / {rs1, rs2, imm, dst}
   localparam int IDEX_CTRL_W  = 8;
   localparam int IDEX_DATA_W  = 101;
   // {mem_read, mem_write, reg_write, mem_to_reg} / {alu_result, store_data, dst}
   localparam int EXMEM_CTRL_W = 4;
   localparam int EXMEM_DATA_W = 69;
   // {reg_write, mem_to_reg} / {mem_data, alu_result, dst}
   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid so
// in_ready is registered; control bits read as zero whenever no entry is held.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = MEMWB_CTRL_W,
   parameter int DATA_W = MEMWB_DATA_W
) (
   input  logic              clk,
   input  logic              startin_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   ps_state_t         state, state_nxt;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              in_fire, out_fire;
   logic              ld_main_in, ld_main_skid, ld_skid;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      // Flush wins: a coinciding in_fire is dropped, out_fire was already taken.
      if (flush) begin
         state_nxt = PS_EMPTY;
      end else begin
         case (state)
            PS_EMPTY: begin
               if (in_fire) begin
                  state_nxt  = PS_ONE;
                  ld_main_in = 1'b1;
               end
            end
            PS_ONE: begin
               if (in_fire && out_fire) begin
                  ld_main_in = 1'b1;
               end else if (in_fire) begin
                  state_nxt = PS_FULL;
                  ld_skid   = 1'b1;
               end else if (out_fire) begin
                  state_nxt = PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  state_nxt    = PS_ONE;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_nxt = PS_EMPTY;
         endcase
      end
   end

   // Slot registers and state: the single stage boundary of this block.
   always_ff @(posedge clk or negedge startin_n) begin
      if (!startin_n) begin
         state     <= PS_EMPTY;
         in_ready  <= 1'b0;
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != PS_FULL);
         if (ld_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (ld_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (ld_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

   assign out_valid = (state != PS_EMPTY);
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then a long random run, all
// checked against a queue model of the entries the stage should be holding.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int CTRL_W = MEMWB_CTRL_W;
   localparam int DATA_W = MEMWB_DATA_W;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic              clk = 1'b0;
   logic              startin_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [OCC_W-1:0]  occupancy;

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .startin_n (startin_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // Reference model: entries held in arrival order, plus the handshake view.
   ent_t              mq[$];
   logic              m_ready;
   logic [DATA_W-1:0] last_data;
   logic [DATA_W-1:0] got[$];
   bit                last_in_fire;
   int                max_occ;
   int                passed = 0;
   int                total  = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ready   = 1'b0;
      last_data = '0;
   endtask

   task automatic check_outputs();
      logic              ev;
      logic [CTRL_W-1:0] ec;
      ev = (mq.size() > 0);
      ec = ev ? mq[0].c : '0;
      chk("in_ready",  DATA_W'(in_ready),  DATA_W'(m_ready));
      chk("out_valid", DATA_W'(out_valid), DATA_W'(ev));
      chk("out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(ec));
      chk("out_data",  out_data,           last_data);
      chk("occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
   endtask

   // One clock edge: apply the handshake rules to the model, then compare.
   task automatic step();
      bit   inf, outf;
      ent_t e;
      @(posedge clk);
      inf  = in_valid && m_ready;
      outf = (mq.size() > 0) && out_ready;
      if (out_valid && out_ready) got.push_back(out_data);
      if (flush) begin
         mq.delete();
      end else begin
         if (outf) void'(mq.pop_front());
         if (inf) begin
            e.c = in_ctrl;
            e.d = in_data;
            mq.push_back(e);
         end
      end
      last_in_fire = inf && !flush;
      m_ready = (mq.size() < 2);
      if (mq.size() > 0) last_data = mq[0].d;
      #1;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      check_outputs();
   endtask

   // Offer data values 1..4 in order; out_ready is low on cycles [slo, shi].
   task automatic stream4(input int slo, input int shi);
      int idx;
      idx = 1;
      got.delete();
      max_occ = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid  = (idx <= 4);
         in_ctrl   = 2'b11;
         in_data   = DATA_W'(idx);
         out_ready = !(cyc >= slo && cyc <= shi);
         step();
         if (last_in_fire) idx++;
      end
      in_valid = 1'b0;
      chk("stream_count", DATA_W'(got.size()), DATA_W'(4));
      for (int i = 0; i < got.size() && i < 4; i++)
         chk("stream_order", got[i], DATA_W'(i + 1));
   endtask

   initial begin
      int c_cnt;
      startin_n = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      out_ready = 1'b1;
      model_reset();
      #12;
      check_outputs();
      #2 startin_n = 1'b1;
      step();
      chk("ready_after_reset", DATA_W'(in_ready), DATA_W'(1));

      // Free-flowing stream: never more than one entry held.
      stream4(100, 100);
      chk("stream_occ_le1", DATA_W'(max_occ <= 1), DATA_W'(1));

      // Stall on cycles 2-3: skid fills, order preserved.
      stream4(2, 3);
      chk("stall_occ2", DATA_W'(max_occ), DATA_W'(2));

      // Control held high with no valid entry must never leak out.
      in_valid = 1'b0;
      in_ctrl  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bubble_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
      end

      // Fill to FULL with 0xA then 0xB, flush while 0xC is offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DATA_W'(32'hA);
      step();
      in_data   = DATA_W'(32'hB);
      step();
      chk("full_occ", DATA_W'(occupancy), DATA_W'(2));
      chk("full_head", out_data, DATA_W'(32'hA));
      in_data = DATA_W'(32'hC);
      flush   = 1'b1;
      got.delete();
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("flush_valid", DATA_W'(out_valid), DATA_W'(0));
      chk("flush_ready", DATA_W'(in_ready), DATA_W'(1));
      for (int i = 0; i < 3; i++) step();
      c_cnt = 0;
      foreach (got[i]) if (got[i] == DATA_W'(32'hC)) c_cnt++;
      chk("flush_no_c", DATA_W'(c_cnt), DATA_W'(0));

      // Asynchronous reset while FULL, between clock edges.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DATA_W'(32'h11);
      step();
      in_data   = DATA_W'(32'h12);
      step();
      chk("pre_reset_occ", DATA_W'(occupancy), DATA_W'(2));
      #2 startin_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #4 startin_n = 1'b1;
      in_data   = DATA_W'(32'h5);
      out_ready = 1'b1;
      #1;
      chk("ready_low_until_edge", DATA_W'(in_ready), DATA_W'(0));
      step();
      chk("no_accept_first_edge", DATA_W'(out_valid), DATA_W'(0));
      step();
      chk("accept_second_edge", out_data, DATA_W'(32'h5));

      // Random traffic against the model.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 99) < 2);
         in_ctrl   = CTRL_W'($urandom);
         in_data   = {$urandom, $urandom, $urandom};
         step();
      end
      flush    = 1'b0;
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
